// File: rtl/aes128_iter_engine.sv
// ---------------------------------------------------------------------------
// aes128_iter_engine
//   Iterative AES-128 encryptor (FIPS-197 byte order: byte 0 = bits [127:120]).
//   One block per request; the round key is expanded on the fly, one round at
//   a time. SBOX_LANES sets how many state bytes are substituted per cycle,
//   trading S-box instances against latency:
//     latency accept -> out_valid = 1 + 10*(16/SBOX_LANES + 4/KL + 1) cycles.
//
// Ports
//   clock      in   1    rising-edge clock
//   reset      in   1    asynchronous, active-high reset
//   in_valid   in   1    request present
//   in_ready   out  1    engine idle and able to accept a request
//   in_text    in   128  plaintext block (sampled on accept only)
//   in_key     in   128  cipher key (sampled on accept only)
//   out_valid  out  1    ciphertext available, held until out_ready
//   out_ready  in   1    sink accepts ciphertext
//   out_text   out  128  ciphertext; holds its value until the next block
//   busy       out  1    high whenever the engine is not idle
//
// Also contains sbox: the combinational AES forward S-box lookup.
// ---------------------------------------------------------------------------

// sbox: forward AES S-box, index -> o, purely combinational.
module sbox (
   input  logic [7:0] index,
   output logic [7:0] o
);

   // Entry 0 is the leftmost byte of the table.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o = SBOX_TABLE[index];

endmodule

module aes128_iter_engine #(
   parameter int SBOX_LANES = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_text,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_text,
   output logic         busy
);

   // Key-substitution lanes: the rotated key word has only four bytes.
   localparam int         KL        = (SBOX_LANES < 4) ? SBOX_LANES : 4;
   localparam logic [3:0] SUB_LAST  = 4'(16 / SBOX_LANES - 1);
   localparam logic [3:0] KSUB_LAST = 4'(4 / KL - 1);

   if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
       SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
      $error("aes128_iter_engine: SBOX_LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [2:0] {IDLE, SUB, KSUB, MIX, OUT} state_t;
   // Packed with ascending index so element 0 is the most significant byte,
   // matching FIPS byte numbering directly.
   typedef logic [0:15][7:0] block_t;
   typedef logic [0:3][7:0]  word_t;

   state_t       state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [3:0]   lane_q, lane_d;
   block_t       st_q, st_d;
   block_t       rk_q, rk_d;
   word_t        tw_q, tw_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] out_text_q, out_text_d;
   logic         out_valid_q, out_valid_d;

   // ---------------------------------------------------------------- helpers
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r of the column-major state rotates left by r columns.
   function automatic block_t shift_rows(input block_t s);
      block_t o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[4*c + r] = s[4*((c + r) % 4) + r];
         end
      end
      return o;
   endfunction

   function automatic block_t mix_columns(input block_t s);
      block_t     o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4*c];
         a1 = s[4*c + 1];
         a2 = s[4*c + 2];
         a3 = s[4*c + 3];
         o[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // --------------------------------------------------------- S-box lanes
   logic [7:0] sub_in  [SBOX_LANES];
   logic [7:0] sub_out [SBOX_LANES];
   logic [7:0] key_in  [KL];
   logic [7:0] key_out [KL];
   logic [3:0] sub_base;
   logic [1:0] key_base;
   word_t      rot_w3;

   // The lane counter selects which group of bytes is processed this cycle.
   assign sub_base = 4'(lane_q * SBOX_LANES);
   assign key_base = 2'(lane_q * KL);
   assign rot_w3   = {rk_q[13], rk_q[14], rk_q[15], rk_q[12]};

   for (genvar l = 0; l < SBOX_LANES; l++) begin : g_sub
      assign sub_in[l] = (state_q == SUB) ? st_q[sub_base + 4'(l)] : 8'h00;
      sbox u_sbox (.index(sub_in[l]), .o(sub_out[l]));
   end

   for (genvar l = 0; l < KL; l++) begin : g_key
      assign key_in[l] = (state_q == KSUB) ? rot_w3[key_base + 2'(l)] : 8'h00;
      sbox u_sbox (.index(key_in[l]), .o(key_out[l]));
   end

   // ------------------------------------------------------ round datapath
   logic [31:0] w0_n, w1_n, w2_n, w3_n;
   block_t      rk_next, sr, mixed, st_mix;

   assign w0_n    = rk_q[0:3] ^ tw_q ^ {rcon_q, 24'h0};
   assign w1_n    = rk_q[4:7] ^ w0_n;
   assign w2_n    = rk_q[8:11] ^ w1_n;
   assign w3_n    = rk_q[12:15] ^ w2_n;
   assign rk_next = {w0_n, w1_n, w2_n, w3_n};
   assign sr      = shift_rows(st_q);
   // The final round has no MixColumns.
   assign mixed   = (round_q == 4'd10) ? sr : mix_columns(sr);
   assign st_mix  = mixed ^ rk_next;

   // --------------------------------------------------------- next state
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      round_d     = round_q;
      lane_d      = lane_q;
      st_d        = st_q;
      rk_d        = rk_q;
      tw_d        = tw_q;
      rcon_d      = rcon_q;
      out_text_d  = out_text_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = in_text ^ in_key;
               rk_d    = in_key;
               round_d = 4'd1;
               lane_d  = 4'd0;
               rcon_d  = 8'h01;
               state_d = SUB;
            end
         end
         SUB: begin
            for (int l = 0; l < SBOX_LANES; l++) begin
               st_d[sub_base + 4'(l)] = sub_out[l];
            end
            if (lane_q == SUB_LAST) begin
               lane_d  = 4'd0;
               state_d = KSUB;
            end else begin
               lane_d = lane_q + 4'd1;
            end
         end
         KSUB: begin
            for (int l = 0; l < KL; l++) begin
               tw_d[key_base + 2'(l)] = key_out[l];
            end
            if (lane_q == KSUB_LAST) begin
               lane_d  = 4'd0;
               state_d = MIX;
            end else begin
               lane_d = lane_q + 4'd1;
            end
         end
         MIX: begin
            st_d   = st_mix;
            rk_d   = rk_next;
            rcon_d = xtime(rcon_q);
            if (round_q == 4'd10) begin
               out_text_d  = st_mix;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               round_d = round_q + 4'd1;
               state_d = SUB;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ----------------------------------------------------------- registers
   // NOTE: non-blocking assignments here so every flop samples the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         round_q     <= 4'd0;
         lane_q      <= 4'd0;
         st_q        <= '0;
         rk_q        <= '0;
         tw_q        <= '0;
         rcon_q      <= 8'h00;
         out_text_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         lane_q      <= lane_d;
         st_q        <= st_d;
         rk_q        <= rk_d;
         tw_q        <= tw_d;
         rcon_q      <= rcon_d;
         out_text_q  <= out_text_d;
         out_valid_q <= out_valid_d;
      end
   end

   // in_ready is gated by reset so it stays low while reset is held.
   assign in_ready  = (state_q == IDLE) && !reset;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_text  = out_text_q;

endmodule

// File: tb/tb_aes128_iter_engine.sv
// ---------------------------------------------------------------------------
// tb_aes128_iter_engine
//   Five engine instances, SBOX_LANES = 1,2,4,8,16 (index g -> 1<<g). Most
//   scenarios drive instance 2 (SBOX_LANES=4); the latency scenario runs all
//   five together. Expected ciphertexts come from a behavioural AES model
//   (S-box derived from the GF(2^8) inverse) and the FIPS-197 vectors, held
//   in a scoreboard queue between accept and output.
// ---------------------------------------------------------------------------
module tb_aes128_iter_engine;

   localparam int NI   = 5;
   localparam int MAIN = 2;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [NI-1:0] in_valid;
   logic [NI-1:0] out_ready;
   logic [127:0]  in_text;
   logic [127:0]  in_key;
   wire  [NI-1:0] in_ready_w;
   wire  [NI-1:0] out_valid_w;
   wire  [NI-1:0] busy_w;
   wire  [127:0]  out_text_w [NI];

   int           checks = 0;
   int           errors = 0;
   logic [127:0] exp_q[$];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      aes128_iter_engine #(.SBOX_LANES(1 << g)) u_dut (
         .clock     (clock),
         .reset     (reset),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready_w[g]),
         .in_text   (in_text),
         .in_key    (in_key),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready[g]),
         .out_text  (out_text_w[g]),
         .busy      (busy_w[g])
      );
   end

   always #5 clock = ~clock;

   // ------------------------------------------------------ reference model
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {m_sbox(tmp[31:24]), m_sbox(tmp[23:16]), m_sbox(tmp[15:8]), m_sbox(tmp[7:0])}
                  ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[4*c + r] ^= w[c][31 - 8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = m_sbox(s[i]);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
         s = t;
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c + r] ^= w[4*rnd + c][31 - 8*r -: 8];
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic int exp_latency(input int lanes);
      int kl;
      kl = (lanes < 4) ? lanes : 4;
      return 1 + 10 * (16 / lanes + 4 / kl + 1);
   endfunction

   // ------------------------------------------------------------- driver
   // Offers one block to instance idx, pushes its expected ciphertext on the
   // accept edge and returns at the first falling edge where out_valid is
   // high. lat counts rising edges from the accept edge to the one that
   // raises out_valid, inclusive.
   task automatic run_block(input int idx, input logic [127:0] key, input logic [127:0] pt,
                            output int lat, output bit got);
      int guard;
      @(negedge clock);
      in_key        = key;
      in_text       = pt;
      in_valid[idx] = 1'b1;
      guard = 0;
      while (!in_ready_w[idx] && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      @(posedge clock);
      exp_q.push_back(aes_model(key, pt));
      lat = 1;
      @(negedge clock);
      in_valid[idx] = 1'b0;
      while (!out_valid_w[idx] && lat < 400) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      got = out_valid_w[idx];
   endtask

   // ------------------------------------------------------------ scenarios
   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++;
      if (in_ready_w[MAIN] !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_w[MAIN]);
      end
      checks++;
      if (out_valid_w[MAIN] !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_w[MAIN]);
      end
      checks++;
      if (out_text_w[MAIN] !== 128'h0) begin
         errors++; $display("FAIL reset_out_text: got %h expected 0", out_text_w[MAIN]);
      end
      checks++;
      if (busy_w !== '0) begin
         errors++; $display("FAIL reset_busy: got %b expected 00000", busy_w);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (in_ready_w !== '1) begin
         errors++; $display("FAIL release_in_ready: got %b expected 11111", in_ready_w);
      end
      checks++;
      if (busy_w !== '0 || out_valid_w !== '0) begin
         errors++; $display("FAIL release_idle: busy %b out_valid %b expected 0", busy_w, out_valid_w);
      end
   endtask

   task automatic test_fips();
      logic [127:0] keys [2];
      logic [127:0] pts  [2];
      logic [127:0] cts  [2];
      logic [127:0] exp_ct;
      int lat;
      bit got;
      keys = '{C1_KEY, B_KEY};
      pts  = '{C1_PT, B_PT};
      cts  = '{C1_CT, B_CT};
      for (int v = 0; v < 2; v++) begin
         run_block(MAIN, keys[v], pts[v], lat, got);
         checks++;
         if (!got) begin
            errors++; $display("FAIL fips%0d_timeout: no out_valid after %0d cycles", v, lat);
         end
         exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
         checks++;
         if (out_text_w[MAIN] !== exp_ct) begin
            errors++; $display("FAIL fips%0d_model: got %h expected %h", v, out_text_w[MAIN], exp_ct);
         end
         checks++;
         if (out_text_w[MAIN] !== cts[v]) begin
            errors++; $display("FAIL fips%0d_vector: got %h expected %h", v, out_text_w[MAIN], cts[v]);
         end
         checks++;
         if (lat != 61) begin
            errors++; $display("FAIL fips%0d_latency: got %0d expected 61", v, lat);
         end
      end
   endtask

   task automatic test_latency();
      int           seen [NI];
      logic [127:0] ct   [NI];
      int           cyc;
      bit           all_seen;
      @(negedge clock);
      in_key   = B_KEY;
      in_text  = B_PT;
      in_valid = '1;
      checks++;
      if (in_ready_w !== '1) begin
         errors++; $display("FAIL lat_ready: got %b expected 11111", in_ready_w);
      end
      for (int i = 0; i < NI; i++) begin
         seen[i] = 0;
         ct[i]   = '0;
      end
      @(posedge clock);
      cyc = 1;
      @(negedge clock);
      in_valid = '0;
      all_seen = 1'b0;
      while (!all_seen && cyc < 260) begin
         all_seen = 1'b1;
         for (int i = 0; i < NI; i++) begin
            if (seen[i] == 0 && out_valid_w[i]) begin
               seen[i] = cyc;
               ct[i]   = out_text_w[i];
            end
            if (seen[i] == 0) all_seen = 1'b0;
         end
         if (!all_seen) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
         end
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (seen[i] != exp_latency(1 << i)) begin
            errors++;
            $display("FAIL lat_lanes%0d: got %0d expected %0d", 1 << i, seen[i], exp_latency(1 << i));
         end
         checks++;
         if (ct[i] !== B_CT) begin
            errors++; $display("FAIL lat_ct_lanes%0d: got %h expected %h", 1 << i, ct[i], B_CT);
         end
      end
      @(negedge clock);
   endtask

   task automatic test_backpressure();
      logic [127:0] exp_ct;
      int  lat;
      bit  got;
      bit  bad_valid, bad_text, bad_ready, bad_busy;
      @(negedge clock);
      out_ready[MAIN] = 1'b0;
      run_block(MAIN, C1_KEY, C1_PT, lat, got);
      exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      checks++;
      if (!got || out_text_w[MAIN] !== exp_ct) begin
         errors++; $display("FAIL bp_result: valid %b got %h expected %h", got, out_text_w[MAIN], exp_ct);
      end
      bad_valid = 0; bad_text = 0; bad_ready = 0; bad_busy = 0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid_w[MAIN] !== 1'b1)   bad_valid = 1;
         if (out_text_w[MAIN] !== exp_ct)  bad_text  = 1;
         if (in_ready_w[MAIN] !== 1'b0)    bad_ready = 1;
         if (busy_w[MAIN] !== 1'b1)        bad_busy  = 1;
         in_valid[MAIN] = 1'b1;
         in_text        = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clock);
      end
      checks++;
      if (bad_valid) begin errors++; $display("FAIL bp_valid_hold: got dropped expected 1"); end
      checks++;
      if (bad_text)  begin errors++; $display("FAIL bp_text_hold: got changed expected %h", exp_ct); end
      checks++;
      if (bad_ready) begin errors++; $display("FAIL bp_in_ready: got 1 expected 0"); end
      checks++;
      if (bad_busy)  begin errors++; $display("FAIL bp_busy: got 0 expected 1"); end
      in_valid[MAIN]  = 1'b0;
      out_ready[MAIN] = 1'b1;
      @(negedge clock);
      checks++;
      if (out_valid_w[MAIN] !== 1'b0 || in_ready_w[MAIN] !== 1'b1 || busy_w[MAIN] !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: out_valid %b in_ready %b busy %b expected 0 1 0",
                  out_valid_w[MAIN], in_ready_w[MAIN], busy_w[MAIN]);
      end
      checks++;
      if (out_text_w[MAIN] !== exp_ct) begin
         errors++; $display("FAIL bp_text_after: got %h expected %h", out_text_w[MAIN], exp_ct);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] keys [8];
      logic [127:0] pts  [8];
      logic [127:0] exp_ct;
      int  n_sent, n_recv, cyc;
      bit  accept;
      for (int i = 0; i < 8; i++) begin
         keys[i] = {$urandom, $urandom, $urandom, $urandom};
         pts[i]  = {$urandom, $urandom, $urandom, $urandom};
      end
      n_sent = 0;
      n_recv = 0;
      cyc    = 0;
      out_ready[MAIN] = 1'b1;
      while (n_recv < 8 && cyc < 2000) begin
         @(negedge clock);
         if (out_valid_w[MAIN]) begin
            exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            checks++;
            if (out_text_w[MAIN] !== exp_ct) begin
               errors++;
               $display("FAIL b2b_block%0d: got %h expected %h", n_recv, out_text_w[MAIN], exp_ct);
            end
            n_recv++;
         end
         accept = 1'b0;
         if (n_sent < 8) begin
            in_valid[MAIN] = 1'b1;
            in_key         = keys[n_sent];
            in_text        = pts[n_sent];
            accept         = in_ready_w[MAIN];
         end else begin
            in_valid[MAIN] = 1'b0;
         end
         @(posedge clock);
         if (accept) begin
            exp_q.push_back(aes_model(keys[n_sent], pts[n_sent]));
            n_sent++;
         end
         cyc++;
      end
      in_valid[MAIN] = 1'b0;
      checks++;
      if (n_recv != 8 || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_count: got %0d blocks, %0d pending expected 8, 0", n_recv, exp_q.size());
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      logic [127:0] exp_ct;
      int  guard, lat;
      bit  got;
      @(negedge clock);
      in_key         = C1_KEY;
      in_text        = C1_PT;
      in_valid[MAIN] = 1'b1;
      guard = 0;
      while (!in_ready_w[MAIN] && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      @(negedge clock);
      in_valid[MAIN] = 1'b0;
      // Cycles 25..30 after accept belong to round 5.
      repeat (27) @(negedge clock);
      checks++;
      if (busy_w[MAIN] !== 1'b1) begin
         errors++; $display("FAIL mid_busy_before: got %b expected 1", busy_w[MAIN]);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid_w[MAIN] !== 1'b0 || out_text_w[MAIN] !== 128'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: out_valid %b out_text %h expected 0 0", out_valid_w[MAIN], out_text_w[MAIN]);
      end
      checks++;
      if (busy_w[MAIN] !== 1'b0 || in_ready_w[MAIN] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_ctrl: busy %b in_ready %b expected 0 0", busy_w[MAIN], in_ready_w[MAIN]);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      checks++;
      if (out_valid_w[MAIN] !== 1'b0 || busy_w[MAIN] !== 1'b0) begin
         errors++;
         $display("FAIL mid_discard: out_valid %b busy %b expected 0 0", out_valid_w[MAIN], busy_w[MAIN]);
      end
      run_block(MAIN, C1_KEY, C1_PT, lat, got);
      exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      checks++;
      if (!got || out_text_w[MAIN] !== C1_CT || out_text_w[MAIN] !== exp_ct) begin
         errors++; $display("FAIL mid_after_ct: got %h expected %h", out_text_w[MAIN], C1_CT);
      end
      checks++;
      if (lat != 61) begin
         errors++; $display("FAIL mid_after_latency: got %0d expected 61", lat);
      end
      @(negedge clock);
   endtask

   // ----------------------------------------------------------- sequence
   initial begin
      in_valid  = '0;
      out_ready = '1;
      in_text   = '0;
      in_key    = '0;
      test_reset();
      test_fips();
      test_latency();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
